// File: rtl/sram_fb_arbiter.sv
// Double-buffered frame store arbiter: display reads (priority) and draw writes share one async SRAM.
// Latency: ack is combinational in the grant cycle; read data valid 2 cycles after ack; write occupies 3 cycles.
// Backpressure: requesters hold req until ack; a pending write is forced after STARVE_LIMIT back-to-back reads.
module sram_fb_arbiter #(
  parameter int OFFS_W       = 19,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_req,
  input  logic [OFFS_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [OFFS_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  input  logic              swap_req,
  input  logic              vsync_pulse,
  output logic              front_buf,
  output logic              swap_done,
  output logic [OFFS_W:0]   SRAM_ADDRESS,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD, WR_SETUP, WR_HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              swap_pend;
  logic              dq_oe;
  logic [DATA_W-1:0] wr_data_q;
  logic              grant_rd;
  logic              grant_wr;

  // The data bus is only driven during the two write cycles; every other cycle it floats.
  assign SRAM_DQ = dq_oe ? wr_data_q : {DATA_W{1'bz}};

  assign rd_ack = grant_rd;
  assign wr_ack = grant_wr;

  // Grant decision for the current IDLE cycle: starved write, then read, then write.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (!Reset && state == IDLE) begin
      if (wr_req && starve_cnt == STARVE_MAX) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end
    end
  end

  // Access sequencer: strobes, address, write data and read capture are all registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      SRAM_ADDRESS <= '0;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      SRAM_UB_N    <= 1'b1;
      SRAM_LB_N    <= 1'b1;
      dq_oe        <= 1'b0;
      wr_data_q    <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            // Buffer select is frozen here so a later swap cannot redirect this access.
            SRAM_ADDRESS <= {front_buf, rd_addr};
            SRAM_CE_N    <= 1'b0;
            SRAM_OE_N    <= 1'b0;
            SRAM_UB_N    <= 1'b0;
            SRAM_LB_N    <= 1'b0;
            state        <= RD;
          end else if (grant_wr) begin
            SRAM_ADDRESS <= {~front_buf, wr_addr};
            wr_data_q    <= wr_data;
            SRAM_CE_N    <= 1'b0;
            SRAM_WE_N    <= 1'b0;
            SRAM_UB_N    <= ~wr_be[1];
            SRAM_LB_N    <= ~wr_be[0];
            dq_oe        <= 1'b1;
            state        <= WR_SETUP;
          end
        end
        RD: begin
          rd_data   <= SRAM_DQ;
          rd_valid  <= 1'b1;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          state     <= IDLE;
        end
        WR_SETUP: begin
          // WE_N rises while data and address stay put, giving the SRAM its hold time.
          SRAM_WE_N <= 1'b1;
          state     <= WR_HOLD;
        end
        WR_HOLD: begin
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          dq_oe     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts reads granted over a waiting write, saturating at the limit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (!wr_req || grant_wr) begin
      starve_cnt <= '0;
    end else if (grant_rd && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Buffer swap: arm on swap_req, flip the front buffer on the next vsync.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      front_buf <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (vsync_pulse && (swap_pend || swap_req)) begin
        front_buf <= ~front_buf;
        swap_done <= 1'b1;
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_fb_arbiter.md
Name: sram_fb_arbiter

Overview:
- Owns the off-chip 16-bit async SRAM that holds two frame buffers.
- Shares it between two requesters:
  - the VGA pixel fetcher, a read port with high priority that must meet a deadline;
  - the draw engine, a write port with low priority.
- Sequences the SRAM control strobes and bus turnaround, and swaps front/back buffers on vertical sync.

Parameters:
- OFFS_W, 19, buffer-relative word address width; physical address = {buffer_select, offset}.
- DATA_W, 16, SRAM data width.
- STARVE_LIMIT, 8, consecutive read grants with a write pending before one write is forced.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- rd_req  in  1  display read request; held until rd_ack.
- rd_addr  in  OFFS_W  offset into the front buffer.
- rd_ack  out  1  one-cycle pulse: request accepted, address latched.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- wr_req  in  1  draw write request; held until wr_ack.
- wr_addr  in  OFFS_W  offset into the back buffer.
- wr_data  in  DATA_W  write data.
- wr_be  in  2  byte enables; [1]=upper byte, [0]=lower byte.
- wr_ack  out  1  one-cycle pulse: write accepted.
- swap_req  in  1  request a buffer swap at the next vsync.
- vsync_pulse  in  1  one-cycle start-of-vblank strobe.
- front_buf  out  1  buffer currently being displayed.
- swap_done  out  1  one-cycle pulse when front_buf toggles.
- SRAM_ADDRESS  out  20  physical address.
- SRAM_DQ  inout  16  data bus.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low controls.

Behaviour:
- Reset values:
  - CE_N, OE_N, WE_N, UB_N, LB_N = 1.
  - SRAM_DQ = Z; SRAM_ADDRESS = 0.
  - rd_ack, rd_valid, wr_ack, swap_done = 0; rd_data = 0.
  - front_buf = 0; swap pending = 0; starvation counter = 0; FSM = IDLE.
- Reset mid-access: every strobe returns high and DQ is released on the next edge. The aborted write has an undefined cell value. No ack or valid is issued for it.
- FSM states: IDLE, RD, WR_SETUP, WR_HOLD. Every access returns to IDLE, which guarantees at least one turnaround cycle with DQ released and OE_N=1.
- IDLE grant rule, evaluated every IDLE cycle:
  - If wr_req and starvation counter == STARVE_LIMIT, grant write.
  - Else if rd_req, grant read.
  - Else if wr_req, grant write.
  - Else stay in IDLE.
- Starvation counter:
  - Increments on each read grant while wr_req=1.
  - Clears on any write grant, or when wr_req=0.
  - Saturates at STARVE_LIMIT.
- Read grant, in cycle T (IDLE):
  - rd_ack=1 in T.
  - SRAM_ADDRESS <= {front_buf, rd_addr}; CE_N <= 0; OE_N <= 0; UB_N = LB_N <= 0.
  - T+1 (RD): SRAM_DQ is sampled into rd_data at the end of the cycle.
  - T+2: rd_valid=1, strobes high, FSM=IDLE.
  - Latency from ack to valid: 2 cycles. Peak read rate: 1 per 2 cycles.
- Write grant, in cycle T (IDLE):
  - wr_ack=1 in T.
  - Address {~front_buf, wr_addr}, data and byte enables are latched.
  - T+1 (WR_SETUP): CE_N=0, WE_N=0, UB_N=~wr_be[1], LB_N=~wr_be[0], DQ driven.
  - T+2 (WR_HOLD): WE_N=1, DQ still driven, address held.
  - T+3: IDLE with DQ released. Peak write rate: 1 per 3 cycles.
- wr_be=00 is still granted and acked. It performs a cycle with UB_N=LB_N=1, so no cell changes.
- Buffer selection: the buffer is latched at grant. A swap during an in-flight access does not alter that access's address.
- Swap handling:
  - swap_req sets pending; further swap_req while pending has no effect.
  - On vsync_pulse with pending set, or with swap_req in the same cycle, front_buf toggles on that edge, swap_done pulses for 1 cycle, and pending clears.
  - vsync_pulse with nothing pending has no effect.
- Idle outputs: outside access states, CE_N=OE_N=WE_N=1 and DQ=Z. ack/valid pulses never exceed one cycle.

Test Plan:
- Read-only: preload offset 0x00010 of buffer 0 with 0xBEEF, rd_req at that offset -> rd_ack at T, SRAM_ADDRESS=0x00010 with OE_N=0 at T+1, rd_valid with rd_data=0xBEEF at T+2.
- Write-only: wr_addr=0x00020, wr_data=0x1234, wr_be=10, front_buf=0 -> SRAM_ADDRESS=0x80020, WE_N low exactly 1 cycle (T+1), UB_N=0, LB_N=1; model shows only the upper byte = 0x12.
- Contention: rd_req and wr_req both asserted continuously, STARVE_LIMIT=8 -> grant order is 8 reads then 1 write, repeating. There is never a cycle with DQ driven while OE_N=0.
- Swap: swap_req at cycle 5, vsync_pulse at cycle 40 -> front_buf 0->1 and swap_done pulse at 40. A second vsync at 80 with no request -> no change. Subsequent reads go to 0x8xxxx.
- Swap mid-write: a write is granted at T with front_buf=0, and vsync with swap pending arrives at T+1 -> the write still targets 0x8xxxx, and front_buf=1 after T+1.
- Reset mid-write: Reset asserted during WR_SETUP -> next edge: WE_N=CE_N=1, DQ=Z, FSM=IDLE, front_buf=0, no rd_valid or wr_ack pulse afterwards until a new request.
